// File: rtl/depar_pkg.sv
//------------------------------------------------------------------------------
// depar_pkg : shared widths, segment layout and write-FSM encoding for the
//             deparser packet buffer.
// Revision  : 1.0
//------------------------------------------------------------------------------
`timescale 1ns/1ps
`default_nettype none

package depar_pkg;

  localparam int C_DATA_W  = 512;
  localparam int C_TUSER_W = 128;
  localparam int C_KEEP_W  = C_DATA_W / 8;

  typedef struct packed {
    logic [C_DATA_W-1:0]  tdata;
    logic [C_TUSER_W-1:0] tuser;
    logic [C_KEEP_W-1:0]  tkeep;
    logic                 tlast;
  } seg_t;

  localparam int C_SEG_W = $bits(seg_t);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_WRITE = 2'd1,
    ST_DROP  = 2'd2
  } wr_state_e;

endpackage

`default_nettype wire

// File: rtl/depar_pkt_buf_ram.sv
//------------------------------------------------------------------------------
// depar_pkt_buf_ram : simple dual-port RAM, synchronous write, asynchronous read.
// Revision          : 1.0
//------------------------------------------------------------------------------
`timescale 1ns/1ps
`default_nettype none

module depar_pkt_buf_ram #(
  parameter int WIDTH      = 8,
  parameter int DEPTH_BITS = 5
) (
  input  logic                  clk,
  input  logic                  i_we,
  input  logic [DEPTH_BITS-1:0] i_waddr,
  input  logic [WIDTH-1:0]      i_wdata,
  input  logic [DEPTH_BITS-1:0] i_raddr,
  output logic [WIDTH-1:0]      o_rdata
);

  logic [WIDTH-1:0] r_mem [2**DEPTH_BITS];

  always_ff @(posedge clk) begin
    if (i_we) begin
      r_mem[i_waddr] <= i_wdata;
    end
  end

  assign o_rdata = r_mem[i_raddr];

endmodule

`default_nettype wire

// File: rtl/depar_pkt_buffer.sv
//------------------------------------------------------------------------------
// depar_pkt_buffer : store-and-forward segment buffer; packets become visible
//                    only when complete and are dropped whole on overflow.
// Revision         : 1.0
//------------------------------------------------------------------------------
`timescale 1ns/1ps
`default_nettype none

module depar_pkt_buffer
  import depar_pkg::*;
#(
  parameter int C_AXIS_DATA_WIDTH  = C_DATA_W,
  parameter int C_AXIS_TUSER_WIDTH = C_TUSER_W,
  parameter int C_DEPTH_BITS       = 5,
  parameter int C_CNT_WIDTH        = 32
) (
  input  logic                            axis_clk,
  input  logic                            reset,
  input  logic [C_AXIS_DATA_WIDTH-1:0]    s_axis_tdata,
  input  logic [C_AXIS_DATA_WIDTH/8-1:0]  s_axis_tkeep,
  input  logic [C_AXIS_TUSER_WIDTH-1:0]   s_axis_tuser,
  input  logic                            s_axis_tlast,
  input  logic                            s_axis_tvalid,
  output logic                            s_axis_tready,
  output logic [C_AXIS_DATA_WIDTH-1:0]    pkt_fifo_tdata,
  output logic [C_AXIS_DATA_WIDTH/8-1:0]  pkt_fifo_tkeep,
  output logic [C_AXIS_TUSER_WIDTH-1:0]   pkt_fifo_tuser,
  output logic                            pkt_fifo_tlast,
  output logic                            pkt_fifo_empty,
  input  logic                            pkt_fifo_rd_en,
  output logic [C_CNT_WIDTH-1:0]          pkt_drop_cnt,
  output logic [C_CNT_WIDTH-1:0]          pkt_commit_cnt
);

  localparam int C_WORD_W = C_AXIS_DATA_WIDTH + C_AXIS_TUSER_WIDTH + C_AXIS_DATA_WIDTH/8 + 1;
  localparam int C_PTR_W  = C_DEPTH_BITS + 1;
  localparam logic [C_PTR_W-1:0] C_FULL = {1'b1, {C_DEPTH_BITS{1'b0}}};

  logic [C_PTR_W-1:0]     r_wr_ptr, r_commit_ptr, r_rd_ptr;
  logic [C_PTR_W-1:0]     w_wr_ptr_nxt, w_commit_ptr_nxt, w_used;
  wr_state_e              r_state, w_state_nxt;
  logic                   r_tready;
  logic [C_CNT_WIDTH-1:0] r_drop_cnt, r_commit_cnt;
  logic                   w_beat, w_has_space, w_we, w_commit_inc, w_drop_inc;
  logic                   w_empty, w_pop;
  logic [C_WORD_W-1:0]    w_wr_word, w_rd_word;

  assign w_beat      = s_axis_tvalid & r_tready;
  assign w_used      = r_wr_ptr - r_rd_ptr;
  assign w_has_space = (w_used != C_FULL);
  assign w_empty     = (r_rd_ptr == r_commit_ptr);
  assign w_pop       = pkt_fifo_rd_en & ~w_empty;

  always_comb begin
    w_state_nxt      = r_state;
    w_wr_ptr_nxt     = r_wr_ptr;
    w_commit_ptr_nxt = r_commit_ptr;
    w_we             = 1'b0;
    w_commit_inc     = 1'b0;
    w_drop_inc       = 1'b0;
    unique case (r_state)
      ST_IDLE, ST_WRITE: begin
        if (w_beat) begin
          if (w_has_space) begin
            w_we         = 1'b1;
            w_wr_ptr_nxt = r_wr_ptr + 1'b1;
            if (s_axis_tlast) begin
              w_commit_ptr_nxt = r_wr_ptr + 1'b1;
              w_commit_inc     = 1'b1;
              w_state_nxt      = ST_IDLE;
            end else begin
              w_state_nxt = ST_WRITE;
            end
          end else begin
            // Out of room: discard whatever part of this packet was written.
            w_wr_ptr_nxt = r_commit_ptr;
            if (s_axis_tlast) begin
              w_drop_inc  = 1'b1;
              w_state_nxt = ST_IDLE;
            end else begin
              w_state_nxt = ST_DROP;
            end
          end
        end
      end
      ST_DROP: begin
        if (w_beat && s_axis_tlast) begin
          w_drop_inc  = 1'b1;
          w_state_nxt = ST_IDLE;
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge axis_clk) begin
    if (reset) begin
      r_state      <= ST_IDLE;
      r_wr_ptr     <= '0;
      r_commit_ptr <= '0;
      r_rd_ptr     <= '0;
      r_tready     <= 1'b0;
      r_drop_cnt   <= '0;
      r_commit_cnt <= '0;
    end else begin
      r_state      <= w_state_nxt;
      r_wr_ptr     <= w_wr_ptr_nxt;
      r_commit_ptr <= w_commit_ptr_nxt;
      r_tready     <= 1'b1;
      if (w_pop)        r_rd_ptr     <= r_rd_ptr + 1'b1;
      if (w_drop_inc)   r_drop_cnt   <= r_drop_cnt + 1'b1;
      if (w_commit_inc) r_commit_cnt <= r_commit_cnt + 1'b1;
    end
  end

  assign w_wr_word = {s_axis_tdata, s_axis_tuser, s_axis_tkeep, s_axis_tlast};

  depar_pkt_buf_ram #(
    .WIDTH      (C_WORD_W),
    .DEPTH_BITS (C_DEPTH_BITS)
  ) u_ram (
    .clk     (axis_clk),
    .i_we    (w_we),
    .i_waddr (r_wr_ptr[C_DEPTH_BITS-1:0]),
    .i_wdata (w_wr_word),
    .i_raddr (r_rd_ptr[C_DEPTH_BITS-1:0]),
    .o_rdata (w_rd_word)
  );

  assign {pkt_fifo_tdata, pkt_fifo_tuser, pkt_fifo_tkeep, pkt_fifo_tlast} = w_rd_word;
  assign pkt_fifo_empty = w_empty;
  assign s_axis_tready  = r_tready;
  assign pkt_drop_cnt   = r_drop_cnt;
  assign pkt_commit_cnt = r_commit_cnt;

endmodule

`default_nettype wire

// File: tb/tb_depar_pkt_buffer.sv
//------------------------------------------------------------------------------
// tb_depar_pkt_buffer : directed scoreboard bench for depar_pkt_buffer.
// Revision            : 1.0
//------------------------------------------------------------------------------
`timescale 1ns/1ps
`default_nettype none

module tb_depar_pkt_buffer;
  import depar_pkg::*;

  logic         axis_clk = 1'b0;
  logic         reset = 1'b1;
  logic [511:0] s_axis_tdata = '0;
  logic [63:0]  s_axis_tkeep = '0;
  logic [127:0] s_axis_tuser = '0;
  logic         s_axis_tlast = 1'b0;
  logic         s_axis_tvalid = 1'b0;
  logic         s_axis_tready;
  logic [511:0] pkt_fifo_tdata;
  logic [63:0]  pkt_fifo_tkeep;
  logic [127:0] pkt_fifo_tuser;
  logic         pkt_fifo_tlast;
  logic         pkt_fifo_empty;
  logic         pkt_fifo_rd_en = 1'b0;
  logic [31:0]  pkt_drop_cnt;
  logic [31:0]  pkt_commit_cnt;

  int   errors = 0;
  int   checks = 0;
  seg_t sb[$];

  always #5 axis_clk = ~axis_clk;

  depar_pkt_buffer dut (
    .axis_clk       (axis_clk),
    .reset          (reset),
    .s_axis_tdata   (s_axis_tdata),
    .s_axis_tkeep   (s_axis_tkeep),
    .s_axis_tuser   (s_axis_tuser),
    .s_axis_tlast   (s_axis_tlast),
    .s_axis_tvalid  (s_axis_tvalid),
    .s_axis_tready  (s_axis_tready),
    .pkt_fifo_tdata (pkt_fifo_tdata),
    .pkt_fifo_tkeep (pkt_fifo_tkeep),
    .pkt_fifo_tuser (pkt_fifo_tuser),
    .pkt_fifo_tlast (pkt_fifo_tlast),
    .pkt_fifo_empty (pkt_fifo_empty),
    .pkt_fifo_rd_en (pkt_fifo_rd_en),
    .pkt_drop_cnt   (pkt_drop_cnt),
    .pkt_commit_cnt (pkt_commit_cnt)
  );

  function automatic logic [127:0] usr(input logic [31:0] id);
    return {4{id ^ 32'h5A5A_0000}};
  endfunction

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Pops and compares every segment the DUT hands over on a read.
  task automatic monitor();
    seg_t act, exp;
    forever begin
      @(negedge axis_clk);
      if (!reset && pkt_fifo_rd_en && !pkt_fifo_empty) begin
        act = {pkt_fifo_tdata, pkt_fifo_tuser, pkt_fifo_tkeep, pkt_fifo_tlast};
        checks++;
        if (sb.size() == 0) begin
          errors++;
          $display("FAIL pop_unexpected: got id %0h last %0b expected no segment",
                   act.tdata[31:0], act.tlast);
        end else begin
          exp = sb.pop_front();
          if (act !== exp) begin
            errors++;
            $display("FAIL pop_segment: got id %0h user %0h keep %0h last %0b expected id %0h user %0h keep %0h last %0b",
                     act.tdata[31:0], act.tuser[31:0], act.tkeep, act.tlast,
                     exp.tdata[31:0], exp.tuser[31:0], exp.tkeep, exp.tlast);
          end
        end
      end
    end
  endtask

  task automatic beat(input logic [31:0] id, input logic [127:0] user, input logic [63:0] keep,
                      input logic last, input bit exp_commit);
    seg_t s;
    s.tdata = {16{id}};
    s.tuser = user;
    s.tkeep = keep;
    s.tlast = last;
    s_axis_tdata  = s.tdata;
    s_axis_tuser  = s.tuser;
    s_axis_tkeep  = s.tkeep;
    s_axis_tlast  = s.tlast;
    s_axis_tvalid = 1'b1;
    if (exp_commit) sb.push_back(s);
    @(posedge axis_clk); #1;
    s_axis_tvalid = 1'b0;
  endtask

  task automatic do_reset();
    reset          = 1'b1;
    s_axis_tvalid  = 1'b0;
    pkt_fifo_rd_en = 1'b0;
    repeat (2) @(posedge axis_clk);
    #1;
    chk("tready_in_reset", 64'(s_axis_tready), 64'd0);
    reset = 1'b0;
    @(posedge axis_clk); #1;
    chk("tready_after_reset", 64'(s_axis_tready), 64'd1);
    chk("empty_after_reset", 64'(pkt_fifo_empty), 64'd1);
    chk("drop_after_reset", 64'(pkt_drop_cnt), 64'd0);
    chk("commit_after_reset", 64'(pkt_commit_cnt), 64'd0);
  endtask

  task automatic drain(input string nm, input int exp_n);
    int n = 0;
    pkt_fifo_rd_en = 1'b1;
    while (!pkt_fifo_empty && n < 64) begin
      @(posedge axis_clk); #1;
      n++;
    end
    pkt_fifo_rd_en = 1'b0;
    chk(nm, 64'(n), 64'(exp_n));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    fork
      monitor();
    join_none

    // Single-segment packet.
    do_reset();
    beat(32'd1, 128'h55, '1, 1'b1, 1'b1);
    chk("t1_empty_latency", 64'(pkt_fifo_empty), 64'd0);
    chk("t1_head_tlast", 64'(pkt_fifo_tlast), 64'd1);
    chk("t1_head_tuser", pkt_fifo_tuser[63:0], 64'h55);
    chk("t1_commit_cnt", 64'(pkt_commit_cnt), 64'd1);
    pkt_fifo_rd_en = 1'b1;
    @(posedge axis_clk); #1;
    pkt_fifo_rd_en = 1'b0;
    chk("t1_empty_after_pop", 64'(pkt_fifo_empty), 64'd1);

    // Three-segment packet with reads held on.
    pkt_fifo_rd_en = 1'b1;
    beat(32'd10, usr(10), {2{32'd10}}, 1'b0, 1'b1);
    chk("t2_empty_seg1", 64'(pkt_fifo_empty), 64'd1);
    beat(32'd11, usr(11), {2{32'd11}}, 1'b0, 1'b1);
    chk("t2_empty_seg2", 64'(pkt_fifo_empty), 64'd1);
    beat(32'd12, usr(12), {2{32'd12}}, 1'b1, 1'b1);
    chk("t2_empty_seg3", 64'(pkt_fifo_empty), 64'd0);
    repeat (3) @(posedge axis_clk);
    #1;
    pkt_fifo_rd_en = 1'b0;
    chk("t2_empty_after_3_pops", 64'(pkt_fifo_empty), 64'd1);
    chk("t2_commit_cnt", 64'(pkt_commit_cnt), 64'd2);

    // 30-segment packet fills; following 4-segment packet is rolled back.
    do_reset();
    for (int i = 0; i < 30; i++) beat(32'd100 + 32'(i), usr(32'd100 + 32'(i)), '1, i == 29, 1'b1);
    for (int i = 0; i < 4; i++)  beat(32'd200 + 32'(i), usr(32'd200 + 32'(i)), '1, i == 3, 1'b0);
    chk("t3_drop_cnt", 64'(pkt_drop_cnt), 64'd1);
    chk("t3_commit_cnt", 64'(pkt_commit_cnt), 64'd1);
    chk("t3_not_empty", 64'(pkt_fifo_empty), 64'd0);
    drain("t3_readable_segs", 30);

    // Oversize packet dropped, next packet commits normally.
    do_reset();
    for (int i = 0; i < 40; i++) beat(32'd300 + 32'(i), usr(32'd300 + 32'(i)), '1, i == 39, 1'b0);
    chk("t4_drop_cnt", 64'(pkt_drop_cnt), 64'd1);
    chk("t4_empty", 64'(pkt_fifo_empty), 64'd1);
    chk("t4_commit_zero", 64'(pkt_commit_cnt), 64'd0);
    beat(32'd400, usr(400), 64'h0000_0000_FFFF_FFFF, 1'b0, 1'b1);
    beat(32'd401, usr(401), 64'h0000_0000_0000_00FF, 1'b1, 1'b1);
    chk("t4_commit_after", 64'(pkt_commit_cnt), 64'd1);
    drain("t4_readable_segs", 2);

    // Back-to-back single-segment packets with continuous reads (wraps pointers).
    do_reset();
    pkt_fifo_rd_en = 1'b1;
    for (int i = 0; i < 100; i++) beat(32'd1000 + 32'(i), usr(32'd1000 + 32'(i)), '1, 1'b1, 1'b1);
    @(posedge axis_clk); #1;
    pkt_fifo_rd_en = 1'b0;
    chk("t5_commit_cnt", 64'(pkt_commit_cnt), 64'd100);
    chk("t5_drop_cnt", 64'(pkt_drop_cnt), 64'd0);
    chk("t5_empty", 64'(pkt_fifo_empty), 64'd1);
    chk("t5_sb_drained", 64'(sb.size()), 64'd0);

    // Reset with a committed packet and a partial packet in flight.
    do_reset();
    beat(32'd500, usr(500), '1, 1'b0, 1'b0);
    beat(32'd501, usr(501), '1, 1'b1, 1'b0);
    beat(32'd502, usr(502), '1, 1'b0, 1'b0);
    beat(32'd503, usr(503), '1, 1'b0, 1'b0);
    chk("t6_pre_reset_not_empty", 64'(pkt_fifo_empty), 64'd0);
    chk("t6_pre_reset_commit", 64'(pkt_commit_cnt), 64'd1);
    reset = 1'b1;
    @(posedge axis_clk); #1;
    reset = 1'b0;
    @(posedge axis_clk); #1;
    chk("t6_empty", 64'(pkt_fifo_empty), 64'd1);
    chk("t6_drop_zero", 64'(pkt_drop_cnt), 64'd0);
    chk("t6_commit_zero", 64'(pkt_commit_cnt), 64'd0);
    beat(32'd600, usr(600), '1, 1'b0, 1'b1);
    beat(32'd601, usr(601), '1, 1'b0, 1'b1);
    beat(32'd602, usr(602), 64'h0F, 1'b1, 1'b1);
    chk("t6_commit_after", 64'(pkt_commit_cnt), 64'd1);
    drain("t6_readable_segs", 3);

    @(posedge axis_clk); #1;
    chk("sb_final_empty", 64'(sb.size()), 64'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/depar_pkt_buffer.md
Name: depar_pkt_buffer

Overview:
Store-and-forward packet buffer directly upstream of the deparser top. It feeds the deparser's pkt_fifo_* inputs.
- Accepts 512-bit AXIS segments from the pipeline's packet-cache path.
- Exposes a packet to the deparser only once its last segment has been written.
- Drops a whole packet, never a partial one, when storage runs out, so the deparser never sees truncated packets.
- The read side is a fallthrough FIFO interface.

Parameters:
C_AXIS_DATA_WIDTH, 512, segment data width
C_AXIS_TUSER_WIDTH, 128, tuser width
C_DEPTH_BITS, 5, log2 of segment slots (32 slots)
C_CNT_WIDTH, 32, width of statistics counters

Ports:
axis_clk  in  1  single clock for all logic
reset  in  1  synchronous, active-high reset
s_axis_tdata  in  C_AXIS_DATA_WIDTH  input segment data
s_axis_tkeep  in  C_AXIS_DATA_WIDTH/8  input byte enables
s_axis_tuser  in  C_AXIS_TUSER_WIDTH  input metadata, stored per segment
s_axis_tlast  in  1  last segment of packet
s_axis_tvalid  in  1  segment valid
s_axis_tready  out  1  held at 1 after reset; overflow is handled by dropping
pkt_fifo_tdata  out  C_AXIS_DATA_WIDTH  head segment data
pkt_fifo_tkeep  out  C_AXIS_DATA_WIDTH/8  head segment keep
pkt_fifo_tuser  out  C_AXIS_TUSER_WIDTH  head segment tuser
pkt_fifo_tlast  out  1  head segment last flag
pkt_fifo_empty  out  1  no committed segment available
pkt_fifo_rd_en  in  1  pop head segment
pkt_drop_cnt  out  C_CNT_WIDTH  packets dropped
pkt_commit_cnt  out  C_CNT_WIDTH  packets committed

Behaviour:
- Clock and reset: one clock, axis_clk. reset is synchronous and active-high.
- Storage: 2^C_DEPTH_BITS entries, each {tdata, tuser, tkeep, tlast}. Write is synchronous; read is asynchronous (fallthrough).
- Pointers: wr_ptr (speculative), commit_ptr and rd_ptr, each C_DEPTH_BITS+1 bits and wrapping naturally.
  - free = 2^C_DEPTH_BITS − (wr_ptr − rd_ptr), computed from the current-cycle registers.
- Reset values:
  - all pointers 0, state IDLE, both counters 0
  - s_axis_tready 0 during reset, 1 from the first cycle after it
  - pkt_fifo_empty 1
  - pkt_fifo_* data outputs: don't care while empty
- Write FSM:
  - IDLE, beat with free>0: write the beat, wr_ptr+1. If tlast: commit_ptr <= wr_ptr+1, commit_cnt+1, stay IDLE. Else go to WRITE.
  - IDLE, beat with free==0: if tlast, drop_cnt+1 and stay IDLE; else go to DROP.
  - WRITE, beat with free>0: write, wr_ptr+1. If tlast: commit, commit_cnt+1, go to IDLE.
  - WRITE, beat with free==0: rollback wr_ptr <= commit_ptr. If tlast: drop_cnt+1 and go to IDLE; else go to DROP.
  - DROP: discard beats. On tlast: drop_cnt+1, go to IDLE.
  - No beat (tvalid=0): hold state and pointers.
- Read side:
  - pkt_fifo_empty = (rd_ptr == commit_ptr).
  - Outputs show mem[rd_ptr] combinationally.
  - rd_en while not empty: rd_ptr+1 on the next edge. rd_en while empty is ignored and rd_ptr is unchanged.
- Latency: a tlast beat accepted at edge N makes empty fall in the cycle after N (one cycle). The head data is valid in that same cycle.
- Simultaneous events:
  - A read and a write in the same cycle are both performed. free uses the pre-edge rd_ptr, so it is conservative by one slot for that cycle.
  - A rollback coinciding with a read is legal, because rd_ptr never passes commit_ptr.
- Oversize packets: a packet longer than 2^C_DEPTH_BITS segments is always dropped.
- Counters wrap at 2^C_CNT_WIDTH.
- Reset mid-operation: all state returns to reset values and buffered packets are discarded. Upstream shares the reset, so the first beat after reset is treated as a packet start.

Decomposition:
- Package depar_pkg holds:
  - width constants (data, tuser, keep)
  - the segment struct {tdata, tuser, tkeep, tlast} and its packed width
  - the write-FSM enum {IDLE, WRITE, DROP}
- One sub-module: depar_pkt_buf_ram, a simple dual-port RAM with synchronous write and asynchronous read, parameterised by width and depth bits.
- Pointer logic, the FSM and the counters stay in the top.

Test Plan:
- Single-segment packet (tlast=1, tkeep all ones, tuser=0x55) → empty falls exactly 1 cycle later; head shows tlast=1 and tuser=0x55; commit_cnt=1; after one rd_en, empty=1.
- 3-segment packet with rd_en held high → empty stays 1 until segment 3 is accepted; the 3 segments pop on 3 consecutive cycles in order; pkt_fifo_tlast=1 only on the third.
- Fill with one 30-segment packet, then a 4-segment packet, with no reads → second packet rolled back at its 3rd beat; empty=0 with exactly 30 segments readable; drop_cnt=1, commit_cnt=1.
- 40-segment packet into an empty buffer → dropped; drop_cnt=1, empty stays 1, wr_ptr equals commit_ptr afterwards. The following 2-segment packet commits normally.
- Continuous 1-segment packets with rd_en every cycle for 100 cycles → no drops, commit_cnt=100, data order preserved, pointer wrap at 32 and 64 exercised.
- Assert reset in the middle of a committed packet plus a partial packet → empty=1, both counters 0; the next packet after reset is delivered intact.
